// File: rtl/bin2bcd_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : bin2bcd_seq_if
//  Purpose  : Handshake bundle for the sequential binary-to-BCD converter.
//             An operand channel (in_valid/in_ready/in_data) and a result
//             channel (out_valid/out_ready/out_bcd/out_overflow).
//  Modports : master - operand producer / result consumer
//             slave  - the converter itself
//  Revision : 1.0 - initial release
// ============================================================================
interface bin2bcd_seq_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_bcd;
    logic                  out_overflow;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_bcd, out_overflow
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_bcd, out_overflow
    );
endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : bin2bcd_seq
//  Purpose  : Sequential double-dabble binary-to-BCD converter, one input bit
//             per clock, with a sticky overflow flag when DIGITS is too small
//             to represent the operand.
//  Ports    : clk   - rising-edge clock
//             rst_n - asynchronous active-low reset
//             bus   - bin2bcd_seq_if.slave
//                     in_valid/in_ready/in_data    : operand handshake
//                     out_valid/out_ready          : result handshake
//                     out_bcd  (4*DIGITS)          : packed BCD, digit 0 LSBs
//                     out_overflow                 : operand >= 10^DIGITS
//  Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    bin2bcd_seq_if.slave   bus
);

    localparam int c_cnt_w = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [WIDTH-1:0]      r_sh_bin;
    logic [4*DIGITS-1:0]   r_bcd;
    logic                  r_ovf;
    logic [c_cnt_w-1:0]    r_cnt;

    // Result registers are separate from the working BCD register so the
    // visible result only changes on the edge that enters DONE.
    logic [4*DIGITS-1:0]   r_out_bcd;
    logic                  r_out_ovf;

    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_last;
    logic [4*DIGITS-1:0]   w_adj;
    logic [4*DIGITS-1:0]   w_bcd_nxt;
    logic [WIDTH-1:0]      w_sh_nxt;
    logic                  w_ovf_nxt;

    // DONE also accepts when the result is being consumed on the same edge,
    // which is what gives back-to-back throughput of WIDTH+1 cycles.
    assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_last     = (r_cnt == c_cnt_w'(1));

    // Add-3 correction on every digit in parallel, using the pre-shift value.
    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        assign w_adj[4*d +: 4] = (r_bcd[4*d +: 4] >= 4'd5) ? (r_bcd[4*d +: 4] + 4'd3)
                                                          : r_bcd[4*d +: 4];
    end

    // {bcd, sh_bin} shifted left as one vector; the MSB of the adjusted top
    // digit falls off the end and marks overflow.
    assign w_bcd_nxt = {w_adj[4*DIGITS-2:0], r_sh_bin[WIDTH-1]};
    assign w_sh_nxt  = r_sh_bin << 1;
    assign w_ovf_nxt = r_ovf | w_adj[4*DIGITS-1];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last)   w_state_nxt = S_DONE;
            S_DONE: begin
                if (w_accept)           w_state_nxt = S_SHIFT;
                else if (bus.out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_bin  <= '0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
            r_cnt     <= '0;
            r_out_bcd <= '0;
            r_out_ovf <= 1'b0;
        end else if (w_accept) begin
            r_sh_bin <= bus.in_data;
            r_bcd    <= '0;
            r_ovf    <= 1'b0;
            r_cnt    <= c_cnt_w'(WIDTH);
        end else if (r_state == S_SHIFT) begin
            r_sh_bin <= w_sh_nxt;
            r_bcd    <= w_bcd_nxt;
            r_ovf    <= w_ovf_nxt;
            r_cnt    <= r_cnt - c_cnt_w'(1);
            if (w_last) begin
                r_out_bcd <= w_bcd_nxt;
                r_out_ovf <= w_ovf_nxt;
            end
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = (r_state == S_DONE);
    assign bus.out_bcd      = r_out_bcd;
    assign bus.out_overflow = r_out_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bin2bcd_seq
//  Purpose  : Self-checking bench for bin2bcd_seq. Three instances:
//             A (8 bits, 3 digits), B (16 bits, 3 digits), C (1 bit, 1 digit).
//             A negedge monitor keeps a queue of accepted operands per
//             instance and compares every valid result against a decimal
//             model built from repeated division by ten.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_err;

    bin2bcd_seq_if #(.WIDTH(8),  .DIGITS(3)) a_bus ();
    bin2bcd_seq_if #(.WIDTH(16), .DIGITS(3)) b_bus ();
    bin2bcd_seq_if #(.WIDTH(1),  .DIGITS(1)) c_bus ();

    bin2bcd_seq #(.WIDTH(8),  .DIGITS(3)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_bus));
    bin2bcd_seq #(.WIDTH(16), .DIGITS(3)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_bus));
    bin2bcd_seq #(.WIDTH(1),  .DIGITS(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(c_bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------------------------------------------------------- helpers
    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got no event, expected one within bound (cycle %0d)", name, cyc);
    endtask

    // Decimal digits by repeated division; leftover quotient means overflow.
    task automatic model(input longint unsigned v, input int dg,
                         output logic [79:0] b, output logic o);
        b = '0;
        for (int k = 0; k < dg; k++) begin
            b[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        o = (v != 0);
    endtask

    // ---------------------------------------------------------------- monitor
    longint unsigned q_val[3][$];
    int              q_acc[3][$];
    bit              prev_ov[3];

    task automatic mon(input int id, input int w, input int dg,
                       input logic iv, input logic ir, input logic ov, input logic ordy,
                       input logic [63:0] din, input logic [79:0] bcd, input logic of);
        logic [79:0] eb;
        logic        eo;
        if (ov) begin
            if (q_val[id].size() == 0) begin
                fail($sformatf("spurious_result%0d", id));
            end else begin
                model(q_val[id][0], dg, eb, eo);
                if (!prev_ov[id])
                    chk($sformatf("latency%0d", id), 80'(cyc - q_acc[id][0]), 80'(w));
                chk($sformatf("bcd%0d", id), bcd, eb);
                chk($sformatf("ovf%0d", id), 80'(of), 80'(eo));
                if (!ordy) chk($sformatf("stall_in_ready%0d", id), 80'(ir), 80'(0));
                if (ordy) begin
                    void'(q_val[id].pop_front());
                    void'(q_acc[id].pop_front());
                end
            end
        end else if (q_val[id].size() != 0 && (cyc - q_acc[id][0]) > w) begin
            fail($sformatf("result_timeout%0d", id));
            void'(q_val[id].pop_front());
            void'(q_acc[id].pop_front());
        end
        if (iv && ir) begin
            q_val[id].push_back(din);
            q_acc[id].push_back(cyc + 1);
        end
        prev_ov[id] = ov;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                q_val[i].delete();
                q_acc[i].delete();
                prev_ov[i] = 1'b0;
            end
        end else begin
            mon(0, 8, 3, a_bus.in_valid, a_bus.in_ready, a_bus.out_valid, a_bus.out_ready,
                64'(a_bus.in_data), 80'(a_bus.out_bcd), a_bus.out_overflow);
            mon(1, 16, 3, b_bus.in_valid, b_bus.in_ready, b_bus.out_valid, b_bus.out_ready,
                64'(b_bus.in_data), 80'(b_bus.out_bcd), b_bus.out_overflow);
            mon(2, 1, 1, c_bus.in_valid, c_bus.in_ready, c_bus.out_valid, c_bus.out_ready,
                64'(c_bus.in_data), 80'(c_bus.out_bcd), c_bus.out_overflow);
        end
    end

    // ---------------------------------------------------------------- drivers
    task automatic set_in(input int id, input logic iv, input longint unsigned v);
        case (id)
            0:       begin a_bus.in_valid = iv; a_bus.in_data = 8'(v);  end
            1:       begin b_bus.in_valid = iv; b_bus.in_data = 16'(v); end
            default: begin c_bus.in_valid = iv; c_bus.in_data = 1'(v);  end
        endcase
    endtask

    function automatic logic rdy(input int id);
        case (id)
            0:       return a_bus.in_ready;
            1:       return b_bus.in_ready;
            default: return c_bus.in_ready;
        endcase
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int id, input longint unsigned v);
        bit ok;
        ok = 1'b0;
        set_in(id, 1'b1, v);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rdy(id)) begin ok = 1'b1; break; end
        end
        if (!ok) fail($sformatf("accept_timeout%0d", id));
        @(posedge clk);
        #1;
        set_in(id, 1'b0, v);
    endtask

    task automatic get_res(input int id, output logic [79:0] bcd, output logic of, output int at);
        bcd = '0; of = 1'b0; at = cyc;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            case (id)
                0: if (a_bus.out_valid) begin bcd = 80'(a_bus.out_bcd); of = a_bus.out_overflow; at = cyc; return; end
                1: if (b_bus.out_valid) begin bcd = 80'(b_bus.out_bcd); of = b_bus.out_overflow; at = cyc; return; end
                default: if (c_bus.out_valid) begin bcd = 80'(c_bus.out_bcd); of = c_bus.out_overflow; at = cyc; return; end
            endcase
        end
        fail($sformatf("out_valid_timeout%0d", id));
    endtask

    // ---------------------------------------------------------------- stimulus
    logic [79:0] rb;
    logic        ro;
    int          t0, t1, t_prev;
    bit          done_a, done_b;

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0;
        a_bus.in_valid = 1'b0; a_bus.in_data = '0; a_bus.out_ready = 1'b1;
        b_bus.in_valid = 1'b0; b_bus.in_data = '0; b_bus.out_ready = 1'b1;
        c_bus.in_valid = 1'b0; c_bus.in_data = '0; c_bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 80'(a_bus.out_valid), 80'(0));
        chk("rst_out_bcd",   80'(a_bus.out_bcd),   80'(0));
        chk("rst_out_ovf",   80'(a_bus.out_overflow), 80'(0));
        chk("rst_in_ready",  80'(a_bus.in_ready),  80'(1));
        chk("rst_in_ready_b", 80'(b_bus.in_ready), 80'(1));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed literals, 8-bit / 3 digits
        send(0, 255); t0 = cyc;
        get_res(0, rb, ro, t1);
        chk("d255_bcd", rb, 80'h255);
        chk("d255_ovf", 80'(ro), 80'(0));
        chk("d255_lat", 80'(t1 - t0), 80'(8));
        @(posedge clk); #1;
        send(0, 0);  get_res(0, rb, ro, t1); chk("d0_bcd", rb, 80'h000);
        @(posedge clk); #1;
        send(0, 99); get_res(0, rb, ro, t1); chk("d99_bcd", rb, 80'h099);
        @(posedge clk); #1;

        // 16-bit / 3 digits overflow boundary
        send(1, 1234); get_res(1, rb, ro, t1);
        chk("b1234_bcd", rb, 80'h234); chk("b1234_ovf", 80'(ro), 80'(1));
        @(posedge clk); #1;
        send(1, 999);  get_res(1, rb, ro, t1);
        chk("b999_bcd", rb, 80'h999);  chk("b999_ovf", 80'(ro), 80'(0));
        @(posedge clk); #1;
        send(1, 1000); get_res(1, rb, ro, t1);
        chk("b1000_bcd", rb, 80'h000); chk("b1000_ovf", 80'(ro), 80'(1));
        @(posedge clk); #1;

        // 1-bit / 1 digit
        send(2, 1); t0 = cyc; get_res(2, rb, ro, t1);
        chk("c1_bcd", rb, 80'h1); chk("c1_lat", 80'(t1 - t0), 80'(1));
        @(posedge clk); #1;
        send(2, 0); get_res(2, rb, ro, t1); chk("c0_bcd", rb, 80'h0);
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) send(2, i & 1);
        repeat (4) @(posedge clk); #1;

        // Back-to-back with in_valid held high
        fork
            begin send(0, 12); send(0, 34); send(0, 56); end
            begin
                get_res(0, rb, ro, t_prev); chk("b2b_12", rb, 80'h012);
                get_res(0, rb, ro, t1);     chk("b2b_34", rb, 80'h034);
                chk("b2b_gap1", 80'(t1 - t_prev), 80'(9)); t_prev = t1;
                get_res(0, rb, ro, t1);     chk("b2b_56", rb, 80'h056);
                chk("b2b_gap2", 80'(t1 - t_prev), 80'(9));
            end
        join
        @(posedge clk); #1;

        // Backpressure: result held, new operand waits for out_ready
        a_bus.out_ready = 1'b0;
        send(0, 77);
        get_res(0, rb, ro, t1);
        chk("bp_first", rb, 80'h077);
        a_bus.in_valid = 1'b1; a_bus.in_data = 8'd5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_stable", 80'(a_bus.out_bcd), 80'h077);
            chk("bp_in_ready", 80'(a_bus.in_ready), 80'(0));
        end
        @(posedge clk); #1;
        a_bus.out_ready = 1'b1;
        @(posedge clk); #1;
        a_bus.in_valid = 1'b0;
        get_res(0, rb, ro, t1);
        chk("bp_next", rb, 80'h005);
        @(posedge clk); #1;

        // Exhaustive 8-bit sweep, back-to-back
        for (int v = 0; v < 256; v++) send(0, v);
        repeat (12) @(posedge clk); #1;

        // Randomised traffic with random backpressure on A and B
        done_a = 1'b0; done_b = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    send(0, $urandom_range(0, 255));
                end
                done_a = 1'b1;
            end
            begin
                while (!done_a) begin @(posedge clk); #1; a_bus.out_ready = ($urandom_range(0, 3) != 0); end
                a_bus.out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 150; i++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    if ($urandom_range(0, 1) == 0) send(1, $urandom_range(0, 1999));
                    else                           send(1, $urandom_range(0, 65535));
                end
                done_b = 1'b1;
            end
            begin
                while (!done_b) begin @(posedge clk); #1; b_bus.out_ready = ($urandom_range(0, 3) != 0); end
                b_bus.out_ready = 1'b1;
            end
        join
        repeat (25) @(posedge clk); #1;

        // Reset in the middle of a conversion of 200
        send(0, 37); get_res(0, rb, ro, t1); chk("pre_rst_37", rb, 80'h037);
        @(posedge clk); #1;
        send(0, 200);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 80'(a_bus.out_valid), 80'(0));
        chk("mid_rst_out_bcd",   80'(a_bus.out_bcd),   80'(0));
        chk("mid_rst_out_ovf",   80'(a_bus.out_overflow), 80'(0));
        chk("mid_rst_in_ready",  80'(a_bus.in_ready),  80'(1));
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (12) @(posedge clk); #1;
        chk("post_rst_idle", 80'(a_bus.out_valid), 80'(0));
        send(0, 37); get_res(0, rb, ro, t1);
        chk("post_rst_37", rb, 80'h037);

        repeat (20) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
